// File: rtl/alu_wb_sequencer.sv
// ALU result write-back sequencer: buffers ALU result sets in a small FIFO
// and drains them to the register file one write per cycle, issuing a
// second write of result2 to rd+1 for paired (complex) operations.
//
// state | meaning
// IDLE  | nothing being written; leaves as soon as the buffer holds or receives an entry
// WR_LO | writing head.result to head.rd
// WR_HI | writing head.result2 to (head.rd + 1) mod 32, then popping the head
module alu_wb_sequencer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] result2,
  input  logic [4:0]  dest_reg,
  input  logic        pair_op,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        pair;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  state_t         state, state_next;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic           push, pop;
  logic           more_after_pop;

  // Ready comes only from the registered count, so a same-cycle pop never opens a full buffer.
  assign in_ready       = (count < CW'(DEPTH));
  assign push           = in_valid && in_ready && !reset;
  assign head           = mem[rd_ptr];
  assign more_after_pop = (count > CW'(1)) || push;
  assign busy           = (count != '0) || (state != IDLE);

  // Next state, pop decision and register-file outputs from state and buffer head.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = 5'd0;
    rf_wdata   = 32'd0;
    case (state)
      IDLE: begin
        if ((count != '0) || push) state_next = WR_LO;
      end
      WR_LO: begin
        rf_addr  = head.rd;
        rf_wdata = head.result;
        rf_we    = (head.rd != 5'd0);
        if (head.pair) begin
          state_next = WR_HI;
        end else begin
          pop        = 1'b1;
          state_next = more_after_pop ? WR_LO : IDLE;
        end
      end
      WR_HI: begin
        rf_addr    = head.rd + 5'd1;
        rf_wdata   = head.result2;
        rf_we      = ((head.rd + 5'd1) != 5'd0);
        pop        = 1'b1;
        state_next = more_after_pop ? WR_LO : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // State, pointers and count; reset drops every buffered entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{result: result, result2: result2, rd: dest_reg, pair: pair_op};
    end
  end

endmodule
